// File: rtl/noc_traffic_pkg.sv
// Shared definitions for the NoC traffic generator/checker endpoint:
// header field positions, FSM encodings and the stall LFSR constants.
package noc_traffic_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_BODY = 2'd2,
    S_GAP  = 2'd3
  } snd_state_e;

  typedef enum logic {
    C_HDR  = 1'b0,
    C_BODY = 1'b1
  } chk_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois mask for x^16 + x^14 + x^13 + x^11 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int dest_x_lsb(input int coord_w);
    return 0;
  endfunction

  function automatic int dest_y_lsb(input int coord_w);
    return coord_w;
  endfunction

  function automatic int src_x_lsb(input int coord_w);
    return 2 * coord_w;
  endfunction

  function automatic int src_y_lsb(input int coord_w);
    return 3 * coord_w;
  endfunction

  function automatic int seq_lsb(input int coord_w);
    return 4 * coord_w;
  endfunction

  function automatic int seq_w(input int data_w, input int coord_w);
    return data_w - 4 * coord_w;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/noc_traffic_checker.sv
// Receive-side integrity checker: validates header destination, payload
// sequence (header + k) and tail position; keeps rx/error counters.
module noc_traffic_checker
  import noc_traffic_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int COORD_W = 2,
  parameter int X_ID    = 0,
  parameter int Y_ID    = 0,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              xfer_i,
  input  logic [DATA_W-1:0] flit_i,
  input  logic              is_header_i,
  input  logic              is_tail_i,
  output logic [CNT_W-1:0]  rx_pkt_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic              err_flag_o
);

  localparam int KW = $clog2(PKT_LEN) + 1;
  localparam logic [KW-1:0] LAST_K = KW'(PKT_LEN - 1);
  localparam int DX_LSB = dest_x_lsb(COORD_W);
  localparam int DY_LSB = dest_y_lsb(COORD_W);

  chk_state_e        state_q, state_d;
  logic [DATA_W-1:0] hdr_q, hdr_d;
  logic [KW-1:0]     k_q, k_d;
  logic              pkt_err_q, pkt_err_d;
  logic [CNT_W-1:0]  rx_q, rx_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              flag_q, flag_d;
  logic              flit_err;
  logic              pkt_ok;

  // NOTE: every variable gets a default first so no path through the
  // process leaves it unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    k_d       = k_q;
    pkt_err_d = pkt_err_q;
    rx_d      = rx_q;
    err_d     = err_q;
    flag_d    = flag_q;
    flit_err  = 1'b0;
    pkt_ok    = 1'b0;

    if (xfer_i) begin
      if (is_header_i) begin
        // A header seen mid-packet is itself an error and restarts the check.
        flit_err  = (state_q == C_BODY) ||
                    (flit_i[DX_LSB +: COORD_W] != COORD_W'(X_ID)) ||
                    (flit_i[DY_LSB +: COORD_W] != COORD_W'(Y_ID));
        hdr_d     = flit_i;
        k_d       = KW'(1);
        pkt_err_d = flit_err;
        state_d   = C_BODY;
      end else if (state_q == C_HDR) begin
        flit_err = 1'b1;
      end else begin
        flit_err = (flit_i != (hdr_q + DATA_W'(k_q))) ||
                   (is_tail_i != (k_q == LAST_K));
        if (is_tail_i || (k_q == LAST_K)) begin
          pkt_ok  = !(pkt_err_q || flit_err);
          state_d = C_HDR;
        end else begin
          k_d       = k_q + 1'b1;
          pkt_err_d = pkt_err_q | flit_err;
        end
      end
    end

    if (flit_err) begin
      flag_d = 1'b1;
      if (err_q != '1) err_d = err_q + 1'b1;
    end
    if (pkt_ok && (rx_q != '1)) rx_d = rx_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= C_HDR;
      hdr_q     <= '0;
      k_q       <= '0;
      pkt_err_q <= 1'b0;
      rx_q      <= '0;
      err_q     <= '0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      k_q       <= k_d;
      pkt_err_q <= pkt_err_d;
      rx_q      <= rx_d;
      err_q     <= err_d;
      flag_q    <= flag_d;
    end
  end

  assign rx_pkt_cnt_o = rx_q;
  assign err_cnt_o    = err_q;
  assign err_flag_o   = flag_q;

endmodule

// File: rtl/noc_traffic_node.sv
// NoC traffic generator/checker endpoint for one router local port.
// Optional macro NOC_TRAFFIC_RANDOM_STALL_EN adds LFSR-driven backpressure.
module noc_traffic_node
  import noc_traffic_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int COORD_W   = 2,
  parameter int MESH_X    = 2,
  parameter int MESH_Y    = 2,
  parameter int X_ID      = 0,
  parameter int Y_ID      = 0,
  parameter int DEST_MODE = 0,
  parameter int DEST_X_ID = 1,
  parameter int DEST_Y_ID = 1,
  parameter int PKT_LEN   = 4,
  parameter int GAP       = 2,
  parameter int NUM_PKTS  = 8,
  parameter int CNT_W     = 16
) (
  input  logic              noc_clk,
  input  logic              noc_rst,
  input  logic              enable,
  output logic              sender_valid,
  input  logic              sender_ready,
  output logic [DATA_W-1:0] sender_flit,
  output logic              sender_is_header,
  output logic              sender_is_tail,
  input  logic              receive_valid,
  output logic              receive_ready,
  input  logic [DATA_W-1:0] receive_flit,
  input  logic              receive_is_header,
  input  logic              receive_is_tail,
  output logic [CNT_W-1:0]  tx_pkt_cnt,
  output logic [CNT_W-1:0]  rx_pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_flag,
  output logic              done
);

  localparam int SEQ_W = seq_w(DATA_W, COORD_W);
  localparam int IW    = $clog2(PKT_LEN) + 1;
  localparam int GW    = $clog2(GAP + 1) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);
  localparam logic [2*COORD_W-1:0] SELF_YX  = {COORD_W'(Y_ID), COORD_W'(X_ID)};
  localparam logic [2*COORD_W-1:0] FIXED_YX = {COORD_W'(DEST_Y_ID), COORD_W'(DEST_X_ID)};

  function automatic logic [2*COORD_W-1:0] rr_step(input logic [2*COORD_W-1:0] yx);
    int x, y;
    x = int'(yx[COORD_W-1:0]) + 1;
    y = int'(yx[2*COORD_W-1:COORD_W]);
    if (x >= MESH_X) begin
      x = 0;
      y = y + 1;
      if (y >= MESH_Y) y = 0;
    end
    return {COORD_W'(y), COORD_W'(x)};
  endfunction

  function automatic logic [2*COORD_W-1:0] rr_next(input logic [2*COORD_W-1:0] yx);
    logic [2*COORD_W-1:0] n;
    n = rr_step(yx);
    if (n == SELF_YX) n = rr_step(n);
    return n;
  endfunction

  localparam logic [2*COORD_W-1:0] DEST_INIT = (DEST_MODE == 1) ? rr_next(SELF_YX) : FIXED_YX;

  snd_state_e           state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [SEQ_W-1:0]     seq_q, seq_d;
  logic [2*COORD_W-1:0] dest_q, dest_d;
  logic [CNT_W-1:0]     tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 rdy_q;
  logic                 head_valid;
  logic                 valid;
  logic                 xfer;
  logic                 last_pkt;
  logic [DATA_W-1:0]    flit;

`ifdef NOC_TRAFFIC_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  logic        stall;
  logic        head_hold_q;

  assign stall         = (lfsr_q[1:0] == 2'b00);
  // Once a header is offered it stays valid until accepted.
  assign head_valid    = head_hold_q || !stall;
  assign receive_ready = rdy_q && !stall;

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      lfsr_q      <= LFSR_SEED;
      head_hold_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_step(lfsr_q);
      if (state_q == S_HEAD && valid) head_hold_q <= !sender_ready;
    end
  end
`else
  assign head_valid    = 1'b1;
  assign receive_ready = rdy_q;
`endif

  assign flit  = {seq_q, SELF_YX, dest_q} + DATA_W'(idx_q);
  assign valid = (state_q == S_BODY) || ((state_q == S_HEAD) && head_valid);
  assign xfer  = valid && sender_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    seq_d    = seq_q;
    dest_d   = dest_q;
    tx_d     = tx_q;
    done_d   = done_q;
    last_pkt = (NUM_PKTS != 0) && (tx_q == CNT_W'(NUM_PKTS - 1));

    case (state_q)
      S_IDLE: if (enable && !done_q) state_d = S_HEAD;
      S_HEAD: begin
        if (xfer) begin
          idx_d   = IW'(1);
          state_d = S_BODY;
        end
      end
      S_BODY: begin
        if (xfer && (idx_q == LAST_IDX)) begin
          if (tx_q != '1) tx_d = tx_q + 1'b1;
          seq_d  = seq_q + 1'b1;
          dest_d = (DEST_MODE == 1) ? rr_next(dest_q) : dest_q;
          done_d = done_q | last_pkt;
          idx_d  = '0;
          gap_d  = '0;
          if (GAP > 0) state_d = S_GAP;
          else state_d = (enable && !done_d) ? S_HEAD : S_IDLE;
        end else if (xfer) begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP - 1)) state_d = (enable && !done_q) ? S_HEAD : S_IDLE;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      seq_q   <= '0;
      dest_q  <= DEST_INIT;
      tx_q    <= '0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      seq_q   <= seq_d;
      dest_q  <= dest_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      rdy_q   <= 1'b1;
    end
  end

  assign sender_valid     = valid;
  assign sender_flit      = valid ? flit : '0;
  assign sender_is_header = valid && (state_q == S_HEAD);
  assign sender_is_tail   = valid && (state_q == S_BODY) && (idx_q == LAST_IDX);
  assign tx_pkt_cnt       = tx_q;
  assign done             = done_q;

  noc_traffic_checker #(
    .DATA_W (DATA_W),
    .COORD_W(COORD_W),
    .X_ID   (X_ID),
    .Y_ID   (Y_ID),
    .PKT_LEN(PKT_LEN),
    .CNT_W  (CNT_W)
  ) u_checker (
    .clk_i       (noc_clk),
    .rst_i       (noc_rst),
    .xfer_i      (receive_valid && receive_ready),
    .flit_i      (receive_flit),
    .is_header_i (receive_is_header),
    .is_tail_i   (receive_is_tail),
    .rx_pkt_cnt_o(rx_pkt_cnt),
    .err_cnt_o   (err_cnt),
    .err_flag_o  (err_flag)
  );

endmodule

// File: tb/tb_noc_traffic_node.sv
// Directed bench: node A(0,0)->(1,1) feeding node B(1,1), plus a round-robin
// node; table-driven checker vectors and hand-written multi-cycle sequences.
module tb_noc_traffic_node;

  logic noc_clk = 1'b0;
  logic noc_rst;
  always #5 noc_clk = ~noc_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Node A (sender under test)
  logic        en_a, a_valid, a_ready, a_hdr, a_tail, a_rx_ready, a_flag, a_done;
  logic [31:0] a_flit;
  logic [15:0] a_tx, a_rx, a_err;
  // Node B (checker under test)
  logic        b_valid, b_hdr, b_tail, b_rx_ready, b_flag, b_done;
  logic [31:0] b_flit;
  logic [15:0] b_tx, b_rx, b_err;
  logic        b_in_valid, b_in_hdr, b_in_tail;
  logic [31:0] b_in_flit;
  // Round-robin node
  logic        en_rr, rr_valid, rr_hdr, rr_tail, rr_rx_ready, rr_flag, rr_done;
  logic [31:0] rr_flit;
  logic [15:0] rr_tx, rr_rx, rr_err;

  // Bench-side link control
  logic        route_ab, tb_a_ready, tb_rv, tb_rh, tb_rt;
  logic [31:0] tb_rf;

  assign a_ready    = tb_a_ready & (route_ab ? b_rx_ready : 1'b1);
  assign b_in_valid = route_ab ? (a_valid & tb_a_ready) : tb_rv;
  assign b_in_flit  = route_ab ? a_flit : tb_rf;
  assign b_in_hdr   = route_ab ? a_hdr : tb_rh;
  assign b_in_tail  = route_ab ? a_tail : tb_rt;

  noc_traffic_node #(.X_ID(0), .Y_ID(0), .DEST_X_ID(1), .DEST_Y_ID(1),
                     .PKT_LEN(4), .GAP(0), .NUM_PKTS(8)) u_a (
    .noc_clk(noc_clk), .noc_rst(noc_rst), .enable(en_a),
    .sender_valid(a_valid), .sender_ready(a_ready), .sender_flit(a_flit),
    .sender_is_header(a_hdr), .sender_is_tail(a_tail),
    .receive_valid(1'b0), .receive_ready(a_rx_ready), .receive_flit(32'h0),
    .receive_is_header(1'b0), .receive_is_tail(1'b0),
    .tx_pkt_cnt(a_tx), .rx_pkt_cnt(a_rx), .err_cnt(a_err), .err_flag(a_flag), .done(a_done));

  noc_traffic_node #(.X_ID(1), .Y_ID(1), .DEST_X_ID(0), .DEST_Y_ID(0),
                     .PKT_LEN(4), .GAP(0), .NUM_PKTS(8)) u_b (
    .noc_clk(noc_clk), .noc_rst(noc_rst), .enable(1'b0),
    .sender_valid(b_valid), .sender_ready(1'b1), .sender_flit(b_flit),
    .sender_is_header(b_hdr), .sender_is_tail(b_tail),
    .receive_valid(b_in_valid), .receive_ready(b_rx_ready), .receive_flit(b_in_flit),
    .receive_is_header(b_in_hdr), .receive_is_tail(b_in_tail),
    .tx_pkt_cnt(b_tx), .rx_pkt_cnt(b_rx), .err_cnt(b_err), .err_flag(b_flag), .done(b_done));

  noc_traffic_node #(.X_ID(0), .Y_ID(0), .DEST_MODE(1),
                     .PKT_LEN(2), .GAP(1), .NUM_PKTS(6)) u_rr (
    .noc_clk(noc_clk), .noc_rst(noc_rst), .enable(en_rr),
    .sender_valid(rr_valid), .sender_ready(1'b1), .sender_flit(rr_flit),
    .sender_is_header(rr_hdr), .sender_is_tail(rr_tail),
    .receive_valid(1'b0), .receive_ready(rr_rx_ready), .receive_flit(32'h0),
    .receive_is_header(1'b0), .receive_is_tail(1'b0),
    .tx_pkt_cnt(rr_tx), .rx_pkt_cnt(rr_rx), .err_cnt(rr_err), .err_flag(rr_flag), .done(rr_done));

  typedef struct {
    logic        v;
    logic        h;
    logic        t;
    logic [31:0] f;
    logic [15:0] exp_err;
    logic [15:0] exp_rx;
    logic        exp_flag;
  } vec_t;

  vec_t vecs[17];
  logic [31:0] rr_exp[6];

  // Flit from (0,0) to (1,1): dest field 4'b0101, seq in bits [31:8].
  function automatic logic [31:0] a_exp_flit(input int pkt, input int k);
    return ((32'(pkt) << 8) | 32'h5) + 32'(k);
  endfunction

  task automatic do_reset();
    noc_rst = 1'b1;
    repeat (2) @(negedge noc_clk);
    noc_rst = 1'b0;
    @(negedge noc_clk);
  endtask

  task automatic wait_flit(input string name, input logic [31:0] f);
    int t;
    t = 0;
    while (!(a_valid && a_flit == f) && t < 60) begin
      @(negedge noc_clk);
      t++;
    end
    check(name, (t < 60), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach summary");
    $fatal(1);
  end

  initial begin
    int t, got;

    // {valid, header, tail, flit, err_cnt, rx_pkt_cnt, err_flag} after the edge
    vecs[0]  = '{1, 1, 0, 32'h004, 1, 0, 1};  // header for (0,1) at node (1,1)
    vecs[1]  = '{1, 0, 0, 32'h005, 1, 0, 1};
    vecs[2]  = '{1, 0, 0, 32'h006, 1, 0, 1};
    vecs[3]  = '{1, 0, 1, 32'h007, 1, 0, 1};
    vecs[4]  = '{0, 0, 0, 32'h000, 1, 0, 1};  // idle
    vecs[5]  = '{1, 1, 0, 32'h105, 1, 0, 1};
    vecs[6]  = '{1, 0, 0, 32'h106, 1, 0, 1};
    vecs[7]  = '{1, 0, 0, 32'hDEAD, 2, 0, 1}; // corrupted payload flit 2
    vecs[8]  = '{1, 0, 1, 32'h108, 2, 0, 1};
    vecs[9]  = '{1, 0, 0, 32'h109, 3, 0, 1};  // orphan body flit
    vecs[10] = '{1, 1, 0, 32'h205, 3, 0, 1};
    vecs[11] = '{1, 0, 0, 32'h206, 3, 0, 1};
    vecs[12] = '{1, 0, 1, 32'h207, 4, 0, 1};  // early tail
    vecs[13] = '{1, 1, 0, 32'h305, 4, 0, 1};  // resync on clean header
    vecs[14] = '{1, 0, 0, 32'h306, 4, 0, 1};
    vecs[15] = '{1, 0, 0, 32'h307, 4, 0, 1};
    vecs[16] = '{1, 0, 1, 32'h308, 4, 1, 1};

    rr_exp = '{32'h001, 32'h104, 32'h205, 32'h301, 32'h404, 32'h505};

    noc_rst = 1'b1; en_a = 1'b0; en_rr = 1'b0; route_ab = 1'b1; tb_a_ready = 1'b1;
    tb_rv = 1'b0; tb_rh = 1'b0; tb_rt = 1'b0; tb_rf = '0;

    // Reset state
    #12;
    check("rst_a_out", {a_valid, a_hdr, a_tail, a_flit}, '0);
    check("rst_a_cnt", {a_tx, a_rx, a_err, a_flag, a_done}, '0);
    check("rst_b_ready", b_rx_ready, 1'b0);
    @(negedge noc_clk);
    noc_rst = 1'b0;
    @(posedge noc_clk);
    #1;
    check("ready_rise", {a_rx_ready, b_rx_ready, rr_rx_ready}, 3'b111);

    // Back-to-back 8 packets, GAP 0
    @(negedge noc_clk);
    en_a = 1'b1;
    t = 0;
    while (!a_valid && t < 20) begin
      @(negedge noc_clk);
      t++;
    end
    check("t1_first_valid", (t < 20), 1'b1);
    for (int c = 0; c <= 32; c++) begin
      if (c < 32) begin
        check($sformatf("t1_flit%0d", c), {a_valid, a_ready, a_hdr, a_tail, a_flit},
              {1'b1, 1'b1, (c % 4) == 0, (c % 4) == 3, a_exp_flit(c / 4, c % 4)});
      end
      if (c == 31) check("t1_done_early", a_done, 1'b0);
      if (c == 32) begin
        check("t1_done", a_done, 1'b1);
        check("t1_idle", a_valid, 1'b0);
        check("t1_counts", {a_tx, b_rx, b_err, b_flag}, {16'd8, 16'd8, 16'd0, 1'b0});
      end
      @(negedge noc_clk);
    end

    // Stall mid-body with enable dropped: packet completes, node idles
    en_a = 1'b0;
    do_reset();
    en_a = 1'b1;
    wait_flit("t2_reach_f1", 32'h006);
    @(negedge noc_clk);
    tb_a_ready = 1'b0;
    en_a = 1'b0;
    for (int s = 0; s < 5; s++) begin
      check($sformatf("t2_hold%0d", s), {a_valid, a_tail, a_flit}, {1'b1, 1'b0, 32'h007});
      @(negedge noc_clk);
    end
    tb_a_ready = 1'b1;
    check("t2_release", {a_valid, a_tail, a_flit}, {1'b1, 1'b0, 32'h007});
    @(negedge noc_clk);
    check("t2_tail", {a_valid, a_tail, a_flit}, {1'b1, 1'b1, 32'h008});
    repeat (4) @(negedge noc_clk);
    check("t2_idle", a_valid, 1'b0);
    check("t2_counts", {a_tx, b_rx, b_err}, {16'd1, 16'd1, 16'd0});

    // Reset during body flit 2 of the third packet
    do_reset();
    en_a = 1'b1;
    wait_flit("t6_reach", 32'h207);
    check("t6_pre_cnt", {a_tx, b_rx}, {16'd2, 16'd2});
    #2;
    noc_rst = 1'b1;
    #1;
    check("t6_async_out", {a_valid, a_hdr, a_tail, a_flit, a_rx_ready}, '0);
    check("t6_async_cnt", {a_tx, a_done, b_rx, b_err, b_flag}, '0);
    @(negedge noc_clk);
    noc_rst = 1'b0;
    t = 0;
    while (!a_valid && t < 20) begin
      @(negedge noc_clk);
      t++;
    end
    check("t6_restart", {a_valid, a_hdr, a_flit}, {1'b1, 1'b1, 32'h005});

    // Checker vectors driven straight into node B
    en_a = 1'b0;
    route_ab = 1'b0;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      tb_rv = vecs[i].v;
      tb_rh = vecs[i].h;
      tb_rt = vecs[i].t;
      tb_rf = vecs[i].f;
      @(posedge noc_clk);
      #1;
      check($sformatf("chk_vec%0d", i), {b_err, b_rx, b_flag},
            {vecs[i].exp_err, vecs[i].exp_rx, vecs[i].exp_flag});
      @(negedge noc_clk);
    end
    tb_rv = 1'b0;

    // Round-robin destinations
    en_rr = 1'b1;
    got = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge noc_clk);
      if (rr_valid && rr_hdr) begin
        if (got < 6) check($sformatf("rr_hdr%0d", got), rr_flit, rr_exp[got]);
        got++;
      end
    end
    check("rr_pkt_total", got, 6);
    check("rr_done", {rr_done, rr_tx}, {1'b1, 16'd6});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
